// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and defaults for the pipeline hazard controller.
//   state_t    : memory-wait FSM states (run / waiting on memory / watchdog error)
//   decision_t : per-cycle control decision, in priority order
package pipe_ctrl_pkg;

  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    D_ERR     = 3'd0,
    D_FREEZE  = 3'd1,
    D_BRANCH  = 3'd2,
    D_LOADUSE = 3'd3,
    D_NORMAL  = 3'd4
  } decision_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock
//   clear : synchronous clear, has priority over inc
//   inc   : count one event this cycle
//   count : current value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush controller for the 5-stage pipeline.
// Decides each cycle whether the PC and each pipeline register load, hold or
// load a bubble, runs a memory-wait watchdog and counts stalls/flushes.
//   clk, reset                    : clock, synchronous active-high reset
//   id_rs1/id_rs2, id_uses_rs1/2  : source operands of the ID instruction
//   ex_rd, ex_memRead             : destination / load flag of the EX instruction
//   ex_branch_taken               : EX branch redirects the PC
//   mem_req, mem_ready            : data-memory handshake of the MEM instruction
//   pc_write, *_write             : load enables for PC and pipeline registers
//   if_id_flush, id_ex_flush      : load a bubble instead of data
//   mem_timeout                   : sticky watchdog error
//   stall_cnt, flush_cnt          : saturating performance counters
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memRead,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = $clog2(TIMEOUT) + 1;

  state_t          state;
  logic [WC_W-1:0] wait_cnt;
  decision_t       decision;
  logic            freeze;
  logic            load_use;

  assign freeze   = mem_req && !mem_ready;
  assign load_use = ex_memRead && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // During a freeze every pipeline register holds, so a pending branch or
  // load-use hazard is still presented on the inputs in the release cycle
  // and is acted on there without any extra latching.
  always_comb begin
    if (state == S_ERR)       decision = D_ERR;
    else if (freeze)          decision = D_FREEZE;
    else if (ex_branch_taken) decision = D_BRANCH;
    else if (load_use)        decision = D_LOADUSE;
    else                      decision = D_NORMAL;
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_timeout  = 1'b0;
    if (reset) begin
      // Hold everything and push bubbles while reset is asserted.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else begin
      case (decision)
        D_ERR, D_FREEZE: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_write = 1'b0;
          mem_wb_write = 1'b0;
          mem_timeout  = (decision == D_ERR);
        end
        D_BRANCH: begin
          // Wrong-path instructions in IF/ID and ID/EX are squashed; this
          // also discards a dependent ID instruction, so no stall is needed.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        D_LOADUSE: begin
          // Hold PC and IF/ID, insert one bubble behind the load.
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // wait_cnt holds the number of consecutive freeze cycles already seen, so
  // the WAIT cycle where it equals TIMEOUT-1 is the TIMEOUT-th such cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (freeze) begin
            state    <= S_WAIT;
            wait_cnt <= WC_W'(1);
          end else begin
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (!freeze) begin
            state    <= S_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
        end
        S_ERR: ;
        default: begin
          state    <= S_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  logic stall_inc;
  logic flush_inc;

  assign stall_inc = !reset && ((decision == D_FREEZE) || (decision == D_LOADUSE));
  assign flush_inc = !reset && (decision == D_BRANCH);

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl with TIMEOUT=4, CNT_W=4.
module tb_pipeline_hazard_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_memRead, ex_branch_taken;
  logic          mem_req, mem_ready;
  logic          pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic          if_id_flush, id_ex_flush, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0]    ctrl;

  assign ctrl = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                 if_id_flush, id_ex_flush};

  pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rd           (ex_rd),
    .ex_memRead      (ex_memRead),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .ex_mem_write    (ex_mem_write),
    .mem_wb_write    (mem_wb_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_timeout     (mem_timeout),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: error flag, length of the current run of consecutive
  // memory-wait cycles, and the two statistics as plain integers.
  bit         m_err;
  int         m_run;
  int         m_stall;
  int         m_flush;
  logic [6:0] exp_ctrl;
  logic       exp_to;

  function automatic bit hazard();
    return ex_memRead && (ex_rd != 0) &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic logic [6:0] model_ctrl();
    if (reset)                   return 7'b00000_11;
    if (m_err)                   return 7'b00000_00;
    if (mem_req && !mem_ready)   return 7'b00000_00;
    if (ex_branch_taken)         return 7'b11111_11;
    if (hazard())                return 7'b00111_01;
    return 7'b11111_00;
  endfunction

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_memRead = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  // Let inputs settle mid-cycle and compute the expected combinational outputs.
  task automatic settle();
    #2;
    exp_ctrl = model_ctrl();
    exp_to   = !reset && m_err;
  endtask

  // Step the model across the rising edge using the inputs that were applied.
  task automatic advance();
    bit fr;
    @(posedge clk);
    fr = mem_req && !mem_ready;
    if (reset) begin
      m_err = 0; m_run = 0; m_stall = 0; m_flush = 0;
    end else if (!m_err) begin
      if ((fr || (!ex_branch_taken && hazard())) && m_stall < CMAX) m_stall++;
      if (!fr && ex_branch_taken && m_flush < CMAX) m_flush++;
      if (fr) begin
        m_run++;
        if (m_run >= TO) m_err = 1;
      end else begin
        m_run = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1; clear_inputs();
    settle();
    advance();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs();
    settle();
    checks++; if (ctrl !== 7'b00000_11) begin errors++; $display("FAIL reset_ctrl got=%b want=%b", ctrl, 7'b00000_11); end
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b want=0", mem_timeout); end
    advance();
    reset = 0;
    settle();
    checks++; if (stall_cnt !== 0 || flush_cnt !== 0) begin errors++; $display("FAIL reset_cnts got=%0d/%0d want=0/0", stall_cnt, flush_cnt); end
    checks++; if (ctrl !== 7'b11111_00) begin errors++; $display("FAIL reset_normal got=%b want=%b", ctrl, 7'b11111_00); end
    advance();
  endtask

  task automatic test_load_use();
    do_reset();
    clear_inputs();
    ex_memRead = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1; id_rs1 = 3; id_uses_rs1 = 1;
    settle();
    checks++; if (ctrl !== 7'b00111_01) begin errors++; $display("FAIL loaduse_ctrl got=%b want=%b", ctrl, 7'b00111_01); end
    advance();
    checks++; if (stall_cnt !== 1) begin errors++; $display("FAIL loaduse_stall got=%0d want=1", stall_cnt); end
    // The load has moved on to MEM: hazard gone, normal flow.
    clear_inputs();
    settle();
    checks++; if (ctrl !== 7'b11111_00) begin errors++; $display("FAIL loaduse_after got=%b want=%b", ctrl, 7'b11111_00); end
    advance();
    // x0 destination never stalls.
    ex_memRead = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1; id_rs2 = 0; id_uses_rs2 = 1;
    settle();
    checks++; if (ctrl !== 7'b11111_00) begin errors++; $display("FAIL loaduse_x0 got=%b want=%b", ctrl, 7'b11111_00); end
    advance();
    checks++; if (stall_cnt !== 1) begin errors++; $display("FAIL loaduse_x0_stall got=%0d want=1", stall_cnt); end
    // Matching register that is not actually read: no stall.
    ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 0; id_rs2 = 2; id_uses_rs2 = 1;
    settle();
    checks++; if (ctrl !== 7'b11111_00) begin errors++; $display("FAIL loaduse_unused got=%b want=%b", ctrl, 7'b11111_00); end
    advance();
    clear_inputs();
  endtask

  task automatic test_branch_loaduse();
    do_reset();
    clear_inputs();
    ex_memRead = 1; ex_rd = 9; id_rs1 = 9; id_uses_rs1 = 1; ex_branch_taken = 1;
    settle();
    checks++; if (ctrl !== 7'b11111_11) begin errors++; $display("FAIL br_lu_ctrl got=%b want=%b", ctrl, 7'b11111_11); end
    advance();
    checks++; if (flush_cnt !== 1 || stall_cnt !== 0) begin errors++; $display("FAIL br_lu_cnts got=%0d/%0d want=1/0", flush_cnt, stall_cnt); end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    do_reset();
    clear_inputs();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (ctrl !== 7'b00000_00) begin errors++; $display("FAIL memwait_freeze[%0d] got=%b want=%b", i, ctrl, 7'b00000_00); end
      advance();
    end
    mem_ready = 1;
    settle();
    checks++; if (ctrl !== 7'b11111_00) begin errors++; $display("FAIL memwait_release got=%b want=%b", ctrl, 7'b11111_00); end
    advance();
    checks++; if (stall_cnt !== 3 || mem_timeout !== 1'b0) begin errors++; $display("FAIL memwait_cnt got=%0d/%b want=3/0", stall_cnt, mem_timeout); end
    // Back in RUN: a fresh 3-cycle wait must not trip the watchdog.
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin settle(); advance(); end
    mem_ready = 1; settle(); advance();
    clear_inputs(); settle();
    checks++; if (mem_timeout !== 1'b0 || ctrl !== 7'b11111_00) begin errors++; $display("FAIL memwait_rerun got=%b/%b want=0/%b", mem_timeout, ctrl, 7'b11111_00); end
    advance();
  endtask

  task automatic test_watchdog();
    do_reset();
    clear_inputs();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < TO; i++) begin
      settle();
      checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL wd_early[%0d] got=%b want=0", i, mem_timeout); end
      advance();
    end
    mem_ready = 1; ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (mem_timeout !== 1'b1 || ctrl !== 7'b00000_00) begin errors++; $display("FAIL wd_err[%0d] got=%b/%b want=1/%b", i, mem_timeout, ctrl, 7'b00000_00); end
      advance();
    end
    checks++; if (flush_cnt !== 0 || stall_cnt !== TO) begin errors++; $display("FAIL wd_cnts got=%0d/%0d want=0/%0d", flush_cnt, stall_cnt, TO); end
    do_reset();
    clear_inputs(); settle();
    checks++; if (mem_timeout !== 1'b0 || ctrl !== 7'b11111_00) begin errors++; $display("FAIL wd_recover got=%b/%b want=0/%b", mem_timeout, ctrl, 7'b11111_00); end
    advance();
    // Ready arriving with the final allowed cycle is a success.
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < TO - 1; i++) begin settle(); advance(); end
    mem_ready = 1; settle(); advance();
    clear_inputs(); settle();
    checks++; if (mem_timeout !== 1'b0 || ctrl !== 7'b11111_00) begin errors++; $display("FAIL wd_lastcycle got=%b/%b want=0/%b", mem_timeout, ctrl, 7'b11111_00); end
    advance();
  endtask

  task automatic test_freeze_branch();
    do_reset();
    clear_inputs();
    ex_branch_taken = 1; mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++; if (ctrl !== 7'b00000_00) begin errors++; $display("FAIL frzbr_freeze[%0d] got=%b want=%b", i, ctrl, 7'b00000_00); end
      advance();
    end
    mem_ready = 1;
    settle();
    checks++; if (ctrl !== 7'b11111_11) begin errors++; $display("FAIL frzbr_release got=%b want=%b", ctrl, 7'b11111_11); end
    advance();
    checks++; if (flush_cnt !== 1 || stall_cnt !== 2) begin errors++; $display("FAIL frzbr_cnts got=%0d/%0d want=1/2", flush_cnt, stall_cnt); end
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    clear_inputs();
    ex_memRead = 1; ex_rd = 12; id_rs1 = 12; id_uses_rs1 = 1;
    for (int i = 0; i < 20; i++) begin settle(); advance(); end
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_stall got=%0d want=15", stall_cnt); end
    clear_inputs(); ex_branch_taken = 1;
    for (int i = 0; i < 18; i++) begin settle(); advance(); end
    checks++; if (flush_cnt !== 4'd15 || stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_flush got=%0d/%0d want=15/15", flush_cnt, stall_cnt); end
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset           = ($urandom_range(0, 39) == 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom);
      id_uses_rs2     = 1'($urandom);
      ex_memRead      = 1'($urandom);
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      mem_req         = ($urandom_range(0, 2) == 0);
      mem_ready       = ($urandom_range(0, 2) == 0);
      settle();
      checks++; if (ctrl !== exp_ctrl || mem_timeout !== exp_to) begin errors++; $display("FAIL rand_ctrl[%0d] got=%b/%b want=%b/%b", i, ctrl, mem_timeout, exp_ctrl, exp_to); end
      advance();
      checks++; if (stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush)) begin errors++; $display("FAIL rand_cnts[%0d] got=%0d/%0d want=%0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush); end
    end
    reset = 0;
    clear_inputs();
  endtask

  initial begin
    m_err = 0; m_run = 0; m_stall = 0; m_flush = 0;
    reset = 1;
    clear_inputs();
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_branch_loaduse();
    test_mem_wait();
    test_watchdog();
    test_freeze_branch();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
